bt_cmd_sched: RTL and testbench

BT_CMD_SCHED -- requirements
Module: bt_cmd_sched

---
 rtl/bt_cmd_sched.sv | 118 +++++++++++
 tb/tb_bt_cmd_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bt_cmd_sched.sv
// UART command-frame parser (A5, cmd, arg[, sum]) feeding a first-word-fall-through command FIFO.
// Optional checksum byte enabled by defining BT_CMD_CHKSUM_EN.
module bt_cmd_sched #(
  parameter int TIMEOUT = 52085,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [2:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [3:0] fifo_count,
  output logic       frame_err,
  output logic       overflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT);

`ifdef BT_CMD_CHKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_ARG, S_SUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_ARG} state_t;
`endif

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic [7:0]      cmd_q;
`ifdef BT_CMD_CHKSUM_EN
  logic [7:0]      arg_q;
`endif
  logic [10:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [3:0]      count_q;
  logic            frame_err_q, overflow_q;

  logic            last_byte, frame_ok, push, do_push, pop, full, timeout_hit;
  logic [7:0]      push_arg;

  always_comb begin
    frame_ok = (cmd_q[7:3] == 5'd0);
`ifdef BT_CMD_CHKSUM_EN
    last_byte = rx_valid && (state_q == S_SUM);
    frame_ok  = frame_ok && (rx_data == 8'(cmd_q + arg_q));
    push_arg  = arg_q;
`else
    last_byte = rx_valid && (state_q == S_ARG);
    push_arg  = rx_data;
`endif
    push        = last_byte && frame_ok;
    pop         = (count_q != 4'd0) && cmd_ready;
    full        = (count_q == 4'(DEPTH));
    // A full FIFO still takes the push when the head leaves on the same edge
    do_push     = push && (!full || pop);
    timeout_hit = (state_q != S_IDLE) && !rx_valid && (timer_q == TW'(TIMEOUT - 2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      cmd_q       <= '0;
`ifdef BT_CMD_CHKSUM_EN
      arg_q       <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= (last_byte && !frame_ok) || timeout_hit;
      overflow_q  <= push && !do_push;

      if (rx_valid || state_q == S_IDLE || timeout_hit) timer_q <= '0;
      else                                              timer_q <= timer_q + TW'(1);

      if (timeout_hit) begin
        state_q <= S_IDLE;
      end else if (rx_valid) begin
        case (state_q)
          S_IDLE: if (rx_data == 8'hA5) state_q <= S_CMD;
          S_CMD: begin
            cmd_q   <= rx_data;
            state_q <= S_ARG;
          end
`ifdef BT_CMD_CHKSUM_EN
          S_ARG: begin
            arg_q   <= rx_data;
            state_q <= S_SUM;
          end
          S_SUM:   state_q <= S_IDLE;
`else
          S_ARG:   state_q <= S_IDLE;
`endif
          default: state_q <= S_IDLE;
        endcase
      end

      if (do_push) begin
        mem_q[wr_ptr_q] <= {cmd_q[2:0], push_arg};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + 4'(do_push) - 4'(pop);
    end
  end

  assign cmd_code   = mem_q[rd_ptr_q][10:8];
  assign cmd_arg    = mem_q[rd_ptr_q][7:0];
  assign cmd_valid  = (count_q != 4'd0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_bt_cmd_sched.sv
// Directed bench for bt_cmd_sched: byte-level frame/queue model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_bt_cmd_sched;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 52085;
`ifdef BT_CMD_CHKSUM_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cmd_ready = 1'b0;
  logic [2:0] cmd_code;
  logic [7:0] cmd_arg;
  logic       cmd_valid;
  logic [3:0] fifo_count;
  logic       frame_err, overflow;

  bt_cmd_sched #(.TIMEOUT(TIMEOUT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_code(cmd_code), .cmd_arg(cmd_arg), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .fifo_count(fifo_count),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int ferr_seen = 0;
  int ovf_seen  = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: queue of collected frame bytes, idle counter, command queue
  logic [7:0]  fb[$];
  logic [10:0] q[$];
  int          gap = 0;

  always @(posedge clk) begin
    int          pre;
    bit          do_pop, have_push, bad, e_ferr, e_ovf;
    logic [10:0] pv;
    e_ferr = 0; e_ovf = 0; have_push = 0; pv = '0;
    if (rst) begin
      q.delete(); fb.delete(); gap = 0;
    end else begin
      pre    = q.size();
      do_pop = cmd_ready && (pre > 0);
      if (rx_valid) begin
        gap = 0;
        if (fb.size() > 0 || rx_data == 8'hA5) fb.push_back(rx_data);
        if (fb.size() == FLEN) begin
          bad = (fb[1] > 8'd7);
`ifdef BT_CMD_CHKSUM_EN
          if (fb[3] != 8'(fb[1] + fb[2])) bad = 1;
`endif
          if (bad) e_ferr = 1;
          else begin have_push = 1; pv = {fb[1][2:0], fb[2]}; end
          fb.delete();
        end
      end else if (fb.size() > 0) begin
        gap++;
        if (gap == TIMEOUT - 1) begin e_ferr = 1; fb.delete(); gap = 0; end
      end
      if (do_pop) void'(q.pop_front());
      if (have_push) begin
        if (pre < DEPTH || do_pop) q.push_back(pv);
        else e_ovf = 1;
      end
    end
    #1;
    if (frame_err) ferr_seen++;
    if (overflow)  ovf_seen++;
    check("cmd_valid", int'(cmd_valid), int'(q.size() != 0));
    check("fifo_count", int'(fifo_count), q.size());
    check("frame_err", int'(frame_err), int'(e_ferr));
    check("overflow", int'(overflow), int'(e_ovf));
    if (rst) begin
      check("rst_code", int'(cmd_code), 0);
      check("rst_arg", int'(cmd_arg), 0);
    end else if (q.size() != 0) begin
      check("head_code", int'(cmd_code), int'(q[0][10:8]));
      check("head_arg", int'(cmd_arg), int'(q[0][7:0]));
    end
  end

  // All stimulus tasks are entered and left on a falling edge
  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a);
    send_byte(8'hA5); send_byte(c); send_byte(a);
`ifdef BT_CMD_CHKSUM_EN
    send_byte(8'(c + a));
`endif
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    repeat (DEPTH + 2) @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  initial begin
    int f0, o0;
    repeat (3) @(negedge clk);
    check("lit_reset_count", int'(fifo_count), 0);
    check("lit_reset_valid", int'(cmd_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    // Good frame; in the 3-byte build the trailing 43 is a discarded idle byte
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h40); send_byte(8'h43);
    check("lit_good_valid", int'(cmd_valid), 1);
    check("lit_good_code", int'(cmd_code), 3);
    check("lit_good_arg", int'(cmd_arg), 8'h40);
    check("lit_good_count", int'(fifo_count), 1);

    f0 = ferr_seen;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h40); send_byte(8'h44);
`ifdef BT_CMD_CHKSUM_EN
    check("lit_badsum_ferr", ferr_seen - f0, 1);
    check("lit_badsum_count", int'(fifo_count), 1);
`else
    check("lit_nosum_ferr", ferr_seen - f0, 0);
    check("lit_nosum_count", int'(fifo_count), 2);
`endif
    drain();
    check("lit_drain_count", int'(fifo_count), 0);

    // Inter-byte timeout, then recovery
    f0 = ferr_seen;
    send_byte(8'hA5); send_byte(8'h03);
    repeat (TIMEOUT) @(negedge clk);
    check("lit_timeout_ferr", ferr_seen - f0, 1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    check("lit_recover_count", int'(fifo_count), 1);
    check("lit_recover_code", int'(cmd_code), 1);
    drain();

    // Reserved command bits set; an A5 mid-frame is consumed as data
    f0 = ferr_seen;
    send_frame(8'h0B, 8'h05);
    send_frame(8'h02, 8'hA5);
    check("lit_badcmd_ferr", ferr_seen - f0, 1);
    check("lit_badcmd_count", int'(fifo_count), 1);
    check("lit_a5arg", int'(cmd_arg), 8'hA5);
    drain();

    // Five frames into a 4-deep FIFO
    o0 = ovf_seen;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 8'(16 * i));
    check("lit_full_count", int'(fifo_count), 4);
    check("lit_overflow", ovf_seen - o0, 1);
    for (int i = 1; i <= 4; i++) begin
      check("lit_order_code", int'(cmd_code), i);
      check("lit_order_arg", int'(cmd_arg), 16 * i);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
    end
    check("lit_empty", int'(cmd_valid), 0);
    cmd_ready = 1'b1;
    repeat (2) @(negedge clk);
    cmd_ready = 1'b0;
    check("lit_empty_ready", int'(fifo_count), 0);

    // Full FIFO, simultaneous push and pop on the final byte
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 8'(i + 1));
    o0 = ovf_seen;
    send_byte(8'hA5); send_byte(8'h06);
`ifdef BT_CMD_CHKSUM_EN
    send_byte(8'h07);
    cmd_ready = 1'b1;
    send_byte(8'h0D);
`else
    cmd_ready = 1'b1;
    send_byte(8'h07);
`endif
    cmd_ready = 1'b0;
    check("lit_pushpop_count", int'(fifo_count), 4);
    check("lit_pushpop_ovf", ovf_seen - o0, 0);
    check("lit_pushpop_head", int'(cmd_code), 2);

    // Reset mid-frame with a full queue
    send_byte(8'hA5); send_byte(8'h03);
    rst = 1'b1;
    @(negedge clk);
    check("lit_rst_count", int'(fifo_count), 0);
    rst = 1'b0;
    @(negedge clk);
    send_frame(8'h05, 8'h07);
    check("lit_post_rst_count", int'(fifo_count), 1);
    check("lit_post_rst_code", int'(cmd_code), 5);
    check("lit_post_rst_arg", int'(cmd_arg), 7);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
